if_prefetch_queue: RTL
======================

IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, 2..16).
REQ-002 SHALL have parameter N, default 32, width of PC and instruction fields.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  branch taken; discard all queued entries.
REQ-006 SHALL have port in_valid  input  1  fetch stage presents a valid PC/Inst pair.
REQ-007 SHALL have port in_pc  input  N  PC of fetched instruction.
REQ-008 SHALL have port in_inst  input  N  fetched instruction word.
REQ-009 SHALL have port in_ready  output  1  queue accepts a push this cycle; fetch freeze = ~in_ready.
REQ-010 SHALL have port out_ready  input  1  decode stage consumes head entry this cycle.
REQ-011 SHALL have port out_valid  output  1  head entry is valid.
REQ-012 SHALL have port out_pc  output  N  PC of head entry.
REQ-013 SHALL have port out_inst  output  N  instruction of head entry.
REQ-014 SHALL have port count  output  clog2(DEPTH+1)  number of occupied entries.

Function
REQ-015 SHALL store entries in FIFO order with N-bit PC and N-bit instruction per entry.
REQ-016 SHALL perform a push on a rising edge when in_valid=1, in_ready=1, flush=0.
REQ-017 SHALL perform a pop on a rising edge when out_valid=1, out_ready=1, flush=0.
REQ-018 SHALL drive in_ready = (count < DEPTH), decoded from registered count only; no dependency on out_ready (no full-bypass).
REQ-019 SHALL drive out_valid = (count != 0), out_pc/out_inst from head entry combinationally from registered state.
REQ-020 SHALL drive out_pc and out_inst to 0 when count = 0.
REQ-021 SHALL make a pushed entry visible at the outputs one cycle after the push edge at the earliest (no input-to-output bypass).
REQ-022 SHALL support simultaneous push and pop in one cycle when 0 < count < DEPTH, count unchanged.
REQ-023 SHALL, when count = DEPTH, allow pop only; count decrements by 1 and in_ready rises the following cycle.
REQ-024 SHALL, when count = 0, ignore out_ready; count increments only on push.
REQ-025 SHALL wrap read and write pointers modulo DEPTH with no gap or duplication.
REQ-026 SHALL, on flush=1 at a rising edge, set count=0 and both pointers to 0, ignoring any simultaneous push or pop.
REQ-027 SHALL deassert out_valid the cycle after a flush edge and accept a push in that same cycle.
REQ-028 SHALL never change count by more than 1 per cycle and never exceed DEPTH or go below 0.

Reset
REQ-029 SHALL, while rst=1, asynchronously force count=0, pointers=0, out_valid=0, out_pc=0, out_inst=0, in_ready=1.
REQ-030 SHALL clear queue contents to 0 on reset; entries are not required to clear on flush.
REQ-031 SHALL, on rst asserted mid-operation, discard all entries; first push after rst release appears at outputs one cycle later.

Verification
REQ-032 Fill: push PC 0,4,8,12 with out_ready=0 -> count=4, in_ready=0, out_pc=0, out_inst=Inst@0.
REQ-033 Drain from full: out_ready=1, in_valid=0 for 4 cycles -> out_pc 0,4,8,12 in order, then out_valid=0, out_pc=0, count=0.
REQ-034 Streaming: in_valid=1, out_ready=1 continuously with DEPTH=4 for 10 pushes -> count holds 1 after first cycle, outputs PC 0..36 in order across pointer wrap.
REQ-035 Full push+pop: count=4, in_valid=1, out_ready=1 -> pop only, count=3, pushed word not stored.
REQ-036 Flush: count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0; push PC 0x40 same cycle -> out_pc=0x40 following cycle.
REQ-037 Async reset: count=2, assert rst between clock edges -> out_valid=0, count=0, in_ready=1 immediately, without a clock edge.

Source files
------------

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue between fetch and decode: a circular FIFO of PC/instruction pairs.
// Push and pop decisions come from registered occupancy only, so no input reaches any output combinationally.
module if_prefetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned N     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [N-1:0]               in_pc,
  input  logic [N-1:0]               in_inst,
  output logic                       in_ready,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [N-1:0]               out_pc,
  output logic [N-1:0]               out_inst,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [N-1:0]  pc_q   [DEPTH];
  logic [N-1:0]  inst_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_pc    = out_valid ? pc_q[rd_ptr_q]   : '0;
  assign out_inst  = out_valid ? inst_q[rd_ptr_q] : '0;
  assign count     = count_q;

  // flush masks both handshakes, so a flushing cycle never moves data
  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        pc_q[wr_ptr_q]   <= in_pc;
        inst_q[wr_ptr_q] <= in_inst;
      end
    end
  end

endmodule
